// File: rtl/clken_gen.sv
// clken_gen: qualifies PLL lock, then drives NCH programmable clock-enable strobes and 50% levels.
// Define CLKEN_FRAC_EN to replace the integer dividers with DIVW-bit phase accumulators.
module clken_gen #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned DIVW        = 16,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned DIV_INIT    = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    locked,
  input  logic                                    sync,
  input  logic                                    cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [DIVW-1:0]                         cfg_div,
  output logic                                    ready,
  output logic [NCH-1:0]                          ce,
  output logic [NCH-1:0]                          lvl
);
  localparam int unsigned LCW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic {WAIT_LOCK, RUN} state_t;

  state_t          state, state_nxt;
  logic [LCW-1:0]  lock_cnt, lock_cnt_nxt;
  logic            ready_nxt;
  logic [NCH-1:0]  ce_nxt, lvl_nxt;
  logic [DIVW-1:0] shadow [NCH];
  logic [DIVW-1:0] shadow_nxt [NCH];
  logic [DIVW-1:0] div [NCH];
  logic [DIVW-1:0] div_nxt [NCH];
  logic [DIVW-1:0] cnt [NCH];
  logic [DIVW-1:0] cnt_nxt [NCH];
`ifdef CLKEN_FRAC_EN
  logic [DIVW:0]   acc_sum [NCH];
`endif

  // Next-state, counter and output logic
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    ready_nxt    = ready;
    ce_nxt       = '0;
    lvl_nxt      = lvl;
    shadow_nxt   = shadow;
    div_nxt      = div;
    cnt_nxt      = cnt;
`ifdef CLKEN_FRAC_EN
    for (int i = 0; i < NCH; i++) begin
      acc_sum[i] = {1'b0, cnt[i]} + {1'b0, div[i]};
    end
`endif

    if (cfg_we && (32'(cfg_ch) < NCH)) begin
      shadow_nxt[cfg_ch] = cfg_div;
    end
`ifdef CLKEN_FRAC_EN
    // increments track the shadow every cycle; no wrap boundary to wait for
    div_nxt = shadow_nxt;
`endif

    case (state)
      WAIT_LOCK: begin
        ready_nxt = 1'b0;
        div_nxt   = shadow_nxt;
        for (int i = 0; i < NCH; i++) begin
          cnt_nxt[i] = '0;
        end
        if (!locked) begin
          lock_cnt_nxt = '0;
        end else if (lock_cnt == LCW'(LOCK_CYCLES - 1)) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end else begin
          lock_cnt_nxt = lock_cnt + LCW'(1);
        end
      end
      RUN: begin
        if (!locked) begin
          state_nxt    = WAIT_LOCK;
          ready_nxt    = 1'b0;
          lock_cnt_nxt = '0;
          lvl_nxt      = '0;
          for (int i = 0; i < NCH; i++) begin
            cnt_nxt[i] = '0;
          end
        end else if (sync) begin
          lvl_nxt = '0;
          div_nxt = shadow_nxt;
          for (int i = 0; i < NCH; i++) begin
            cnt_nxt[i] = '0;
          end
        end else begin
          for (int i = 0; i < NCH; i++) begin
`ifdef CLKEN_FRAC_EN
            cnt_nxt[i] = acc_sum[i][DIVW-1:0];
            ce_nxt[i]  = acc_sum[i][DIVW];
            lvl_nxt[i] = lvl[i] ^ acc_sum[i][DIVW];
`else
            // a divider of 0 behaves as 1: every cycle is a wrap
            if ((div[i] == '0) || (cnt[i] == div[i] - DIVW'(1))) begin
              cnt_nxt[i] = '0;
              ce_nxt[i]  = 1'b1;
              lvl_nxt[i] = ~lvl[i];
              div_nxt[i] = shadow[i];
            end else begin
              cnt_nxt[i] = cnt[i] + DIVW'(1);
            end
`endif
          end
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= WAIT_LOCK;
      lock_cnt <= '0;
      ready    <= 1'b0;
      ce       <= '0;
      lvl      <= '0;
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= DIVW'(DIV_INIT);
        div[i]    <= DIVW'(DIV_INIT);
        cnt[i]    <= '0;
      end
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      ready    <= ready_nxt;
      ce       <= ce_nxt;
      lvl      <= lvl_nxt;
      shadow   <= shadow_nxt;
      div      <= div_nxt;
      cnt      <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_clken_gen.sv
// Self-checking bench for clken_gen (NCH=2, DIVW=16, LOCK_CYCLES=8, DIV_INIT=2).
// Expected {ready, ce[1:0], lvl[1:0]} words are queued per edge and checked after it.
module tb_clken_gen;
  logic        clk = 1'b0;
  logic        rst_n, locked, sync, cfg_we;
  logic [0:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        ready;
  logic [1:0]  ce, lvl;

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q [$];

  clken_gen #(.NCH(2), .DIVW(16), .LOCK_CYCLES(8), .DIV_INIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked), .sync(sync), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .ready(ready), .ce(ce), .lvl(lvl)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {ready, ce, lvl};
  endfunction

  function automatic logic [4:0] mk(input logic r, input logic c1, input logic c0,
                                    input logic l1, input logic l0);
    return {r, c1, c0, l1, l0};
  endfunction

  task automatic test_reset;
    logic [4:0] e;
    rst_n = 1'b0; locked = 1'b0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = 1'b0; cfg_div = '0;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(5'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset edge %0d: got {ready,ce,lvl}=%b want %b", k, obs(), e);
      end
    end
    rst_n = 1'b1;
  endtask

  // locked high from edge 1: ready after edge 8, then default divide-by-2
  task automatic test_lock(input bit run_part);
    logic [4:0] e;
    int m;
    locked = 1'b1;
    for (int k = 1; k <= (run_part ? 12 : 8); k++) begin
      m = k - 8;
      e = mk(k >= 8, m > 0 && m % 2 == 0, m > 0 && m % 2 == 0,
             m > 0 && (m / 2) % 2 == 1, m > 0 && (m / 2) % 2 == 1);
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL lock edge %0d: got {ready,ce,lvl}=%b want %b", k, obs(), e);
      end
    end
  endtask

  // mid-run reset, then a one-cycle lock drop after 5 locked edges
  task automatic test_lock_glitch;
    logic [4:0] e;
    rst_n = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 2) rst_n = 1'b1;
      locked = (k != 1) && (k != 7);
      e = mk(k == 15, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL lock_glitch edge %0d: got {ready,ce,lvl}=%b want %b", k, obs(), e);
      end
    end
  endtask

  // ch0=3, ch1=1 written before lock
  task automatic test_cfg_prelock;
    logic [4:0] e;
    int m;
    rst_n = 1'b0; locked = 1'b0;
    exp_q.push_back(5'b0);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL cfg_prelock reset: got {ready,ce,lvl}=%b want %b", obs(), e);
    end
    rst_n = 1'b1; locked = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cfg_we = (k <= 2); cfg_ch = (k == 2); cfg_div = (k == 1) ? 16'd3 : 16'd1;
      m = k - 8;
      e = mk(k >= 8, m > 0, m > 0 && m % 3 == 0, m > 0 && m % 2 == 1,
             m > 0 && (m / 3) % 2 == 1);
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL cfg_prelock edge %0d: got {ready,ce,lvl}=%b want %b", k, obs(), e);
      end
    end
    cfg_we = 1'b0;
  endtask

  // runs right after a ce0: ch0 -> 5 (after current period), ch1 -> 0 (acts as 1)
  task automatic test_reconfig;
    logic [4:0] e;
    for (int j = 1; j <= 14; j++) begin
      cfg_we = (j <= 2); cfg_ch = (j == 2); cfg_div = (j == 1) ? 16'd5 : 16'd0;
      e = mk(1'b1, 1'b1, j == 3 || j == 8 || j == 13, j % 2 == 1, ((j + 2) / 5) % 2 == 1);
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reconfig edge %0d: got {ready,ce,lvl}=%b want %b", j, obs(), e);
      end
    end
    cfg_we = 1'b0;
  endtask

  // lock loss clears outputs; relock, then sync realigns both channels
  task automatic test_unlock_sync;
    logic [4:0] e;
    int m, s;
    for (int k = 1; k <= 19; k++) begin
      locked = (k > 2);
      sync = (k == 13);
      m = k - 10;
      s = k - 13;
      if (k <= 10)      e = mk(k == 10, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (k <= 12) e = mk(1'b1, 1'b1, 1'b0, m % 2 == 1, 1'b0);
      else if (k == 13) e = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      else              e = mk(1'b1, 1'b1, s == 5, s % 2 == 1, s >= 5);
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL unlock_sync edge %0d: got {ready,ce,lvl}=%b want %b", k, obs(), e);
      end
    end
    sync = 1'b0;
  endtask

  // phase accumulators: 0x4000 -> 1/4, 0x6000 -> 3/8, then both 0
  task automatic test_frac;
    logic [4:0] e;
    int m;
    rst_n = 1'b0; locked = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; locked = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      m = k - 8;
      cfg_we = (k <= 2) || (m == 17) || (m == 18);
      cfg_ch = (k == 2) || (m == 18);
      cfg_div = (k == 1) ? 16'h4000 : (k == 2) ? 16'h6000 : 16'h0000;
      if (m <= 16)
        e = mk(k >= 8, m > 0 && (3 * m) / 8 != (3 * (m - 1)) / 8, m > 0 && m % 4 == 0,
               m > 0 && ((3 * m) / 8) % 2 == 1, m > 0 && (m / 4) % 2 == 1);
      else
        e = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL frac edge %0d: got {ready,ce,lvl}=%b want %b", k, obs(), e);
      end
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
`ifdef CLKEN_FRAC_EN
    test_lock(1'b0);
    test_lock_glitch();
    test_frac();
`else
    test_lock(1'b1);
    test_lock_glitch();
    test_cfg_prelock();
    test_reconfig();
    test_unlock_sync();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end
endmodule
